// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - multi-channel down-counting timer with shared prescaler and Avalon-MM register access
module multi_channel_timer #(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999,
    parameter int PRE_W        = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [5:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);
    localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(RESET_PERIOD);
    localparam logic [3:0]       NUM_CH_L   = 4'(NUM_CH);

    localparam logic [1:0] REG_STATUS    = 2'd0;
    localparam logic [1:0] REG_CONTROL   = 2'd1;
    localparam logic [1:0] REG_PERIOD    = 2'd2;
    localparam logic [1:0] GREG_PRESCALE = 2'd0;
    localparam logic [1:0] GREG_IRQ_PEND = 2'd1;

    logic [NUM_CH-1:0] to_q, to_d, run_q, run_d;
    logic [NUM_CH-1:0] ito, ch_wr, timeout;
    logic [3:0]        ctrl_q   [NUM_CH];
    logic [3:0]        ctrl_d   [NUM_CH];
    logic [CNT_W-1:0]  period_q [NUM_CH];
    logic [CNT_W-1:0]  period_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [CNT_W-1:0]  snap_q   [NUM_CH];
    logic [CNT_W-1:0]  snap_d   [NUM_CH];
    logic [PRE_W-1:0]  prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
    logic [31:0]       readdata_q, readdata_d;

    logic       wr_en, glob_sel, ch_valid, tick;
    logic [2:0] ch_idx;
    logic [1:0] reg_idx;

    assign wr_en    = chipselect & ~write_n;
    assign glob_sel = address[5];
    assign ch_idx   = address[4:2];
    assign reg_idx  = address[1:0];
    assign ch_valid = ({1'b0, ch_idx} < NUM_CH_L);
    assign tick     = (pre_cnt_q == prescale_q);

    // Prescaler: a PRESCALE write restarts the count so the new ratio applies from a clean phase.
    always_comb begin
        prescale_d = prescale_q;
        pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
        if (wr_en && glob_sel && (reg_idx == GREG_PRESCALE)) begin
            prescale_d = writedata[PRE_W-1:0];
            pre_cnt_d  = '0;
        end
    end

    // Later assignments win: register writes override tick behaviour, except TO where set wins.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i]    = wr_en & ~glob_sel & ch_valid & (ch_idx == 3'(i));
            ito[i]      = ctrl_q[i][0];
            timeout[i]  = run_q[i] & tick & (cnt_q[i] == '0);
            to_d[i]     = to_q[i];
            run_d[i]    = run_q[i];
            ctrl_d[i]   = ctrl_q[i];
            period_d[i] = period_q[i];
            cnt_d[i]    = cnt_q[i];
            snap_d[i]   = snap_q[i];

            if (run_q[i] && tick) begin
                if (cnt_q[i] == '0) begin
                    to_d[i]  = 1'b1;
                    cnt_d[i] = period_q[i];
                    if (!ctrl_q[i][1]) begin
                        run_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end

            if (ch_wr[i]) begin
                case (reg_idx)
                    REG_STATUS: begin
                        if (!timeout[i]) begin
                            to_d[i] = 1'b0;
                        end
                    end
                    REG_CONTROL: begin
                        ctrl_d[i] = writedata[3:0];
                        if (writedata[2]) begin
                            run_d[i] = 1'b1;
                        end else if (writedata[3]) begin
                            run_d[i] = 1'b0;
                        end
                    end
                    REG_PERIOD: begin
                        period_d[i] = writedata[CNT_W-1:0];
                        cnt_d[i]    = writedata[CNT_W-1:0];
                        run_d[i]    = 1'b0;
                    end
                    default: begin
                        snap_d[i] = cnt_q[i];
                    end
                endcase
            end
        end
    end

    always_comb begin
        readdata_d = '0;
        if (glob_sel) begin
            case (reg_idx)
                GREG_PRESCALE: readdata_d[PRE_W-1:0]  = prescale_q;
                GREG_IRQ_PEND: readdata_d[NUM_CH-1:0] = to_q & ito;
                default:       readdata_d             = '0;
            endcase
        end else if (ch_valid) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 3'(i)) begin
                    case (reg_idx)
                        REG_STATUS:  readdata_d[1:0]       = {run_q[i], to_q[i]};
                        REG_CONTROL: readdata_d[3:0]       = ctrl_q[i];
                        REG_PERIOD:  readdata_d[CNT_W-1:0] = period_q[i];
                        default:     readdata_d[CNT_W-1:0] = snap_q[i];
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_q       <= '0;
            run_q      <= '0;
            prescale_q <= '0;
            pre_cnt_q  <= '0;
            readdata_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ctrl_q[i]   <= '0;
                period_q[i] <= RST_PERIOD;
                cnt_q[i]    <= RST_PERIOD;
                snap_q[i]   <= '0;
            end
        end else begin
            to_q       <= to_d;
            run_q      <= run_d;
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
            readdata_q <= readdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                ctrl_q[i]   <= ctrl_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
                snap_q[i]   <= snap_d[i];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(to_q & ito);

endmodule

// File: tb/tb_multi_channel_timer.sv
// tb/tb_multi_channel_timer.sv - directed self-checking bench for multi_channel_timer
module tb_multi_channel_timer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        chipselect;
    logic        write_n;
    logic [5:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    multi_channel_timer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .write_n   (write_n),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Returns the register value as it stood when the task was called.
    task automatic rd(input logic [5:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("FAIL reset_readdata: got %0h expected 0", readdata); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %0b expected 0", irq); end
        reset_n = 1'b1;
        rd(6'd2, v);
        n_checks++; if (v !== 32'd49999) begin n_errors++; $display("FAIL reset_period: got %0d expected 49999", v); end
        rd(6'd1, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL reset_control: got %0h expected 0", v); end
        rd(6'd32, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL reset_prescale: got %0h expected 0", v); end
        wr(6'd3, 32'h0);
        rd(6'd3, v);
        n_checks++; if (v !== 32'd49999) begin n_errors++; $display("FAIL reset_counter: got %0d expected 49999", v); end
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        wr(6'd2, 32'd3);
        wr(6'd1, 32'h7);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            n_checks++; if (irq !== (k == 4)) begin n_errors++; $display("FAIL periodic_irq_%0d: got %0b expected %0b", k, irq, (k == 4)); end
        end
        wr(6'd0, 32'h0);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL periodic_clear: got %0b expected 0", irq); end
        for (int k = 8; k <= 10; k++) begin
            @(negedge clk);
            n_checks++; if (irq !== (k == 10)) begin n_errors++; $display("FAIL periodic_irq2_%0d: got %0b expected %0b", k, irq, (k == 10)); end
        end
        rd(6'd0, v);
        n_checks++; if (v !== 32'h3) begin n_errors++; $display("FAIL periodic_status: got %0h expected 3", v); end
        wr(6'd1, 32'h8);
        wr(6'd0, 32'h0);
    endtask

    task automatic test_one_shot();
        logic [31:0] v;
        wr(6'd6, 32'd2);
        wr(6'd5, 32'h4);
        repeat (6) @(negedge clk);
        rd(6'd4, v);
        n_checks++; if (v !== 32'h1) begin n_errors++; $display("FAIL oneshot_status: got %0h expected 1", v); end
        wr(6'd7, 32'h0);
        rd(6'd7, v);
        n_checks++; if (v !== 32'd2) begin n_errors++; $display("FAIL oneshot_counter: got %0d expected 2", v); end
        rd(6'd5, v);
        n_checks++; if (v !== 32'h4) begin n_errors++; $display("FAIL oneshot_control: got %0h expected 4", v); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL oneshot_irq: got %0b expected 0", irq); end
    endtask

    task automatic test_prescale();
        logic [31:0] v;
        logic [31:0] snap_exp [4];
        snap_exp = '{32'd1, 32'd1, 32'd1, 32'd0};
        wr(6'd32, 32'd4);
        wr(6'd10, 32'd1);
        wr(6'd9, 32'h7);
        for (int k = 3; k <= 10; k++) begin
            @(negedge clk);
            n_checks++; if (irq !== (k == 10)) begin n_errors++; $display("FAIL prescale_irq_%0d: got %0b expected %0b", k, irq, (k == 10)); end
        end
        wr(6'd8, 32'h0);
        for (int k = 12; k <= 20; k++) begin
            @(negedge clk);
            n_checks++; if (irq !== (k == 20)) begin n_errors++; $display("FAIL prescale_irq_%0d: got %0b expected %0b", k, irq, (k == 20)); end
        end
        for (int j = 0; j < 4; j++) begin
            wr(6'd11, 32'h0);
            rd(6'd11, v);
            n_checks++; if (v !== snap_exp[j]) begin n_errors++; $display("FAIL prescale_snap_%0d: got %0d expected %0d", j, v, snap_exp[j]); end
        end
        wr(6'd9, 32'h8);
        wr(6'd8, 32'h0);
        wr(6'd32, 32'h0);
    endtask

    task automatic test_period_reload();
        logic [31:0] v;
        wr(6'd1, 32'h6);
        wr(6'd2, 32'd9);
        rd(6'd0, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL reload_status: got %0h expected 0", v); end
        wr(6'd3, 32'h0);
        rd(6'd3, v);
        n_checks++; if (v !== 32'd9) begin n_errors++; $display("FAIL reload_counter: got %0d expected 9", v); end
        wr(6'd1, 32'hC);
        rd(6'd0, v);
        n_checks++; if (v !== 32'h2) begin n_errors++; $display("FAIL reload_start_status: got %0h expected 2", v); end
        wr(6'd3, 32'h0);
        rd(6'd3, v);
        n_checks++; if (v !== 32'd8) begin n_errors++; $display("FAIL reload_decrement: got %0d expected 8", v); end
        wr(6'd1, 32'h8);
    endtask

    task automatic test_status_race();
        logic [31:0] v;
        wr(6'd14, 32'd0);
        wr(6'd13, 32'h7);
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL race_irq_first: got %0b expected 1", irq); end
        wr(6'd12, 32'h0);
        rd(6'd12, v);
        n_checks++; if (v !== 32'h3) begin n_errors++; $display("FAIL race_status: got %0h expected 3", v); end
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL race_irq_held: got %0b expected 1", irq); end
        rd(6'd33, v);
        n_checks++; if (v !== 32'h8) begin n_errors++; $display("FAIL irq_pend: got %0h expected 8", v); end
        wr(6'd22, 32'h1234);
        rd(6'd22, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL ch5_period: got %0h expected 0", v); end
        rd(6'd34, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL global_unused: got %0h expected 0", v); end
        wr(6'd13, 32'h8);
        wr(6'd12, 32'h0);
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL race_irq_cleared: got %0b expected 0", irq); end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] v;
        wr(6'd2, 32'd1);
        wr(6'd1, 32'h7);
        address = 6'd2;
        @(negedge clk);
        n_checks++; if (readdata !== 32'd1) begin n_errors++; $display("FAIL midrun_period: got %0d expected 1", readdata); end
        @(negedge clk);
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL midrun_irq: got %0b expected 1", irq); end
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("FAIL midrun_readdata: got %0h expected 0", readdata); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL midrun_irq_after: got %0b expected 0", irq); end
        rd(6'd2, v);
        n_checks++; if (v !== 32'd49999) begin n_errors++; $display("FAIL midrun_period_rst: got %0d expected 49999", v); end
        rd(6'd0, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL midrun_status: got %0h expected 0", v); end
        rd(6'd1, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL midrun_control: got %0h expected 0", v); end
        rd(6'd3, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL midrun_snap: got %0h expected 0", v); end
        rd(6'd12, v);
        n_checks++; if (v !== 32'h0) begin n_errors++; $display("FAIL midrun_ch3_status: got %0h expected 0", v); end
        wr(6'd3, 32'h0);
        rd(6'd3, v);
        n_checks++; if (v !== 32'd49999) begin n_errors++; $display("FAIL midrun_counter: got %0d expected 49999", v); end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_one_shot();
        test_prescale();
        test_period_reload();
        test_status_race();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
